// File: rtl/result_packer.sv
// result_packer: captures an ALU result and serializes it as a framed packet on a valid/ready byte stream
module result_packer #(
  parameter int datawidth_p = 8,
  parameter int result_width_p = 32,
  parameter int header_en_p = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic [7:0]                opcode_i,
  input  logic [result_width_p-1:0] result_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      valid_o,
  output logic [datawidth_p-1:0]    data_o,
  input  logic                      ready_i
);
  localparam int nb = result_width_p / 8;
  localparam int tot = (header_en_p != 0 ? 4 : 0) + nb;
  localparam int ofs = header_en_p != 0 ? 0 : 4;
  localparam int iw = $clog2(4 + nb);
  localparam logic [15:0] len = 16'(4 + nb);
  localparam logic [iw-1:0] last = iw'(tot - 1);
  typedef enum logic [1:0] {StIdle, StHdr, StData, StDone} state_t;
  state_t state, state_n;
  logic [iw-1:0] idx, idx_n;
  logic [7:0] op_q, op_n;
  logic [result_width_p-1:0] res_q, res_n;
  logic [datawidth_p-1:0] data_n;
  function automatic logic [datawidth_p-1:0] pick(input logic [iw-1:0] k, input logic [7:0] op,
                                                  input logic [result_width_p-1:0] res);
    logic [8*(4+nb)-1:0] s;
    s = {op, 8'h00, len[7:0], len[15:8], res} >> (8 * (3 + nb - ofs - int'(k)));
    return s[datawidth_p-1:0];
  endfunction
  always_comb begin
    state_n = state;
    idx_n = idx;
    op_n = op_q;
    res_n = res_q;
    data_n = data_o;
    if (state == StIdle) begin
      if (start_i) begin
        op_n = opcode_i;
        res_n = result_i;
        idx_n = '0;
        data_n = pick('0, opcode_i, result_i);
        state_n = header_en_p != 0 ? StHdr : StData;
      end
    end else if (state == StDone) begin
      state_n = StIdle;
    end else if (ready_i) begin
      if (idx == last) begin
        state_n = StDone;
      end else begin
        idx_n = idx + iw'(1);
        data_n = pick(idx_n, op_q, res_q);
        state_n = (header_en_p != 0 && int'(idx_n) < 4) ? StHdr : StData;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= StIdle;
      idx <= '0;
      op_q <= '0;
      res_q <= '0;
      data_o <= '0;
      valid_o <= 1'b0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      op_q <= op_n;
      res_q <= res_n;
      data_o <= data_n;
      valid_o <= state_n == StHdr || state_n == StData;
      busy_o <= state_n != StIdle;
      done_o <= state_n == StDone;
    end
  end
endmodule

// File: doc/result_packer.md
Name: result_packer

Overview:
Transmit-side counterpart to the byte-stream operand consumers. It captures a 32-bit ALU result and serializes it into a response packet on an 8-bit valid/ready byte stream. The byte stream feeds the UART transmitter. Packet format matches the command framing: 4-byte header (opcode, reserved 0x00, length LSB, length MSB) followed by the result bytes, MSB first.

Parameters:
datawidth_p, 8, byte-stream width; only 8 is supported.
result_width_p, 32, result width; must be a multiple of 8 (result bytes NB = result_width_p/8).
header_en_p, 1, 1 = emit the 4-byte header before the data; 0 = emit data bytes only.

Ports:
clk_i  input  1  clock; all logic on rising edge
rst_i  input  1  reset; synchronous, active-high
start_i  input  1  request to send a packet; sampled only in StIdle
opcode_i  input  8  opcode echoed in header byte 0; captured with start_i
result_i  input  result_width_p  result value; captured with start_i
busy_o  output  1  high from the cycle after accepted start_i through the StDone cycle
done_o  output  1  one-cycle pulse after the last byte is accepted
valid_o  output  datawidth_p-bit stream valid (1 bit)
data_o  output  datawidth_p  current stream byte
ready_i  input  1  downstream (UART TX) ready; a byte transfers when valid_o && ready_i

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: busy_o=0, done_o=0, valid_o=0, data_o=0x00. State=StIdle, counters=0, capture registers=0.
- All outputs are driven directly from flops; there is no combinational path from ready_i or start_i to any output.
- States: StIdle, StHdr, StData, StDone.
- StIdle:
  - valid_o=0.
  - On start_i=1: capture opcode_i and result_i, clear byte index, and load data_o with the first byte.
  - Go to StHdr (header_en_p=1) or StData (header_en_p=0).
- Latency: start_i accepted in cycle N gives valid_o=1 in cycle N+1 with the first byte.
- StHdr:
  - Emits, in order: opcode, 0x00, len[7:0], len[15:8], where len = 4 + NB (0x0008 at default).
  - On each transfer, advance the index and load the next byte into data_o in the same edge.
  - valid_o stays high, so back-to-back transfers at one byte per cycle are possible when ready_i is held high.
  - After the 4th header transfer, go to StData with data_o = result byte NB-1 (MSB).
- StData:
  - Emits result bytes MSB first: result[31:24], [23:16], [15:8], [7:0].
  - On the final transfer, go to StDone and drop valid_o to 0.
- StDone:
  - done_o=1 for exactly this one cycle; busy_o=1.
  - Unconditionally return to StIdle next cycle.
  - start_i is ignored in StDone.
- Handshake rules:
  - While valid_o=1 and ready_i=0, data_o and valid_o hold stable indefinitely.
  - valid_o is never withdrawn before a transfer.
- start_i outside StIdle is ignored. The captured values are unaffected by later changes of result_i or opcode_i.
- Total packet length: 8 bytes (header_en_p=1) or 4 bytes (header_en_p=0). At least one idle cycle (StDone) separates consecutive packets.
- Reset mid-packet:
  - The packet is aborted.
  - valid_o, busy_o and done_o are 0 on the cycle after the reset edge; no partial byte is re-emitted.
  - The next start_i sends a fresh full packet.
- Simultaneous rst_i and start_i: reset wins and the packet is not started.
- Byte index counter is sized to ceil(log2(4+NB)) bits and never wraps during a packet.

Test Plan:
1. Basic packet: reset, start_i with opcode=0x01, result=0x1234_5678, ready_i=1 constantly.
   - Stream is 01 00 08 00 12 34 56 78 on 8 consecutive cycles starting the cycle after start.
   - done_o pulses once one cycle after byte 78 is accepted; busy_o spans start+1 through done.
2. Backpressure: same packet with ready_i toggling 1,0,0,1,...
   - Every byte appears exactly once, in order; data_o is stable while ready_i=0; no gaps are introduced by the block.
3. Start while busy: assert start_i with result=0xDEAD_BEEF mid-packet.
   - It is ignored; the original bytes continue.
   - After done_o, a new start sends 0xDE 0xAD 0xBE 0xEF after its header.
4. Reset mid-packet: assert rst_i after the 3rd byte.
   - valid_o, busy_o and done_o are 0 the next cycle.
   - A subsequent start with result=0xFFFF_FFFF emits the full 8-byte packet ending FF FF FF FF.
5. header_en_p=0, result=0x0000_0001, ready_i=1.
   - Stream is 00 00 00 01; done_o pulses; exactly 4 transfers.
6. Back-to-back: start_i held high continuously.
   - Packets repeat with exactly one idle cycle (StDone) plus one StIdle cycle between the last byte of one packet and the first byte of the next.
